// File: rtl/io_port_bank.sv
// io_port_bank: PORTx / DDRx / PINx register bank for I/O ports B, C and D.
// External pins pass through a SYNC_STAGES-deep synchroniser before they are readable as PINx.
module io_port_bank #(
  parameter int IO_WIDTH    = 8,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_write,
  input  logic                io_read,
  input  logic [7:0]          io_address,
  input  logic [IO_WIDTH-1:0] io_wdata,
  output logic [IO_WIDTH-1:0] io_rdata,
  output logic                io_rvalid,
  input  logic [IO_WIDTH-1:0] pinb_in,
  input  logic [IO_WIDTH-1:0] pinc_in,
  input  logic [IO_WIDTH-1:0] pind_in,
  output logic [IO_WIDTH-1:0] portb_out,
  output logic [IO_WIDTH-1:0] portc_out,
  output logic [IO_WIDTH-1:0] portd_out,
  output logic [IO_WIDTH-1:0] ddrb_out,
  output logic [IO_WIDTH-1:0] ddrc_out,
  output logic [IO_WIDTH-1:0] ddrd_out
);
  localparam int NPORTS = 3;

  // Strobe protocol: io_write / io_read are single-cycle pulses with no backpressure. Each read
  // strobe is answered exactly one cycle later with io_rvalid high for that cycle; io_rdata
  // holds its last value at all other times. Port p occupies addresses 3p (PIN), 3p+1 (PORT), 3p+2 (DDR).

  logic [IO_WIDTH-1:0] pin_w  [NPORTS];
  logic [IO_WIDTH-1:0] port_q [NPORTS];
  logic [IO_WIDTH-1:0] port_d [NPORTS];
  logic [IO_WIDTH-1:0] ddr_q  [NPORTS];
  logic [IO_WIDTH-1:0] ddr_d  [NPORTS];
  logic [IO_WIDTH-1:0] sync_q [NPORTS][SYNC_STAGES];
  logic [IO_WIDTH-1:0] rdata_q;
  logic [IO_WIDTH-1:0] rdata_d;
  logic                rvalid_q;
  logic                rvalid_d;

  assign pin_w[0] = pinb_in;
  assign pin_w[1] = pinc_in;
  assign pin_w[2] = pind_in;

  // Writing a PIN address toggles the matching PORT register.
  always_comb begin : write_decode
    for (int p = 0; p < NPORTS; p++) begin
      port_d[p] = port_q[p];
      ddr_d[p]  = ddr_q[p];
      if (io_write) begin
        if (io_address == 8'(3 * p))          port_d[p] = port_q[p] ^ io_wdata;
        else if (io_address == 8'(3 * p + 1)) port_d[p] = io_wdata;
        else if (io_address == 8'(3 * p + 2)) ddr_d[p]  = io_wdata;
      end
    end
  end

  // Read data comes from the current (pre-write) state; unmapped addresses return zero.
  always_comb begin : read_mux
    rdata_d  = rdata_q;
    rvalid_d = io_read;
    if (io_read) begin
      rdata_d = '0;
      for (int p = 0; p < NPORTS; p++) begin
        if (io_address == 8'(3 * p))          rdata_d = sync_q[p][SYNC_STAGES-1];
        else if (io_address == 8'(3 * p + 1)) rdata_d = port_q[p];
        else if (io_address == 8'(3 * p + 2)) rdata_d = ddr_q[p];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NPORTS; p++) begin
        port_q[p] <= '0;
        ddr_q[p]  <= '0;
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[p][s] <= '0;
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        port_q[p]    <= port_d[p];
        ddr_q[p]     <= ddr_d[p];
        sync_q[p][0] <= pin_w[p];
        for (int s = 1; s < SYNC_STAGES; s++) sync_q[p][s] <= sync_q[p][s-1];
      end
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign io_rdata  = rdata_q;
  assign io_rvalid = rvalid_q;
  assign portb_out = port_q[0];
  assign portc_out = port_q[1];
  assign portd_out = port_q[2];
  assign ddrb_out  = ddr_q[0];
  assign ddrc_out  = ddr_q[1];
  assign ddrd_out  = ddr_q[2];

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Memory-mapped I/O register bank for ports B, C and D of the microcomputer. Sits directly downstream of the control unit's EXECUTE state. Executes the register side of OUT and IN: stores PORTx/DDRx, synchronises external pins into PINx, and returns read data on the I/O bus. Addresses match the package I/O map: PINB=0x00, PORTB=0x01, DDRB=0x02, PINC=0x03, PORTC=0x04, DDRC=0x05, PIND=0x06, PORTD=0x07, DDRD=0x08.

## Interface
- IO_WIDTH, 8, bits per port and per data bus.
- SYNC_STAGES, 2, flip-flop stages on each pin input; legal range 2..4.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- io_write  in  1  write strobe; one-cycle pulse from EXECUTE of OUT.
- io_read  in  1  read strobe; one-cycle pulse from EXECUTE of IN.
- io_address  in  8  I/O register address.
- io_wdata  in  IO_WIDTH  write data (source CPU register).
- io_rdata  out  IO_WIDTH  registered read data.
- io_rvalid  out  1  high for one cycle when io_rdata holds the result of a read.
- pinb_in, pinc_in, pind_in  in  IO_WIDTH each  asynchronous external pin levels.
- portb_out, portc_out, portd_out  out  IO_WIDTH each  PORTx register contents (pad drive value).
- ddrb_out, ddrc_out, ddrd_out  out  IO_WIDTH each  DDRx register contents (1 = pad output enable).

## Operation
- Write to PORTx or DDRx: register loads io_wdata at the strobe edge.
- Write to PINx: PORTx ^= io_wdata (bitwise toggle); PINx itself is not writable.
- Read PINx: returns the last synchroniser stage for port x, regardless of DDRx.
- Read PORTx/DDRx: returns current register value.
- Unmapped address (0x09..0xFF): write ignored; read returns 0x00 with io_rvalid still asserted.
- io_write and io_read together: both performed. A read returns the pre-write value, including same-address PORTx/DDRx and toggle cases.
- io_rdata holds its value between reads. It changes only on a read strobe or reset.
- Synchroniser: each pin bit is a chain of SYNC_STAGES flops, clocked every cycle, independent of strobes.

## Timing
- Reset (any cycle, including with a strobe active): all PORTx, DDRx, synchroniser flops, io_rdata = 0x00; io_rvalid = 0. A strobe coincident with reset is discarded.
- Write latency: register and its *_out port show the new value in the cycle after the strobe edge.
- Read latency: io_rvalid and io_rdata valid in the cycle after the strobe. io_rvalid deasserts the following cycle unless another read is strobed.
- Back-to-back reads on consecutive cycles: io_rvalid stays high, and each cycle's data corresponds to the previous cycle's address.
- Pin-to-PIN latency: a pin change stable before edge N appears at the last synchroniser stage after edge N+SYNC_STAGES-1. A read strobed in the following cycle returns it one cycle later.
- Write then immediate read of the same PORTx/DDRx on the next cycle returns the new value.

## Test plan
- Reset: drive strobes and pins = 0xFF during reset -> after release, all *_out = 0x00, io_rdata = 0x00, io_rvalid = 0; PINB reads 0xFF only after SYNC_STAGES cycles.
- Write/readback: OUT DDRC=0x0F, OUT PORTC=0xA5 -> ddrc_out = 0x0F and portc_out = 0xA5 one cycle after each strobe; IN PORTC -> io_rdata = 0xA5, io_rvalid pulse 1 cycle.
- Toggle: PORTB = 0x3C, then write PINB = 0x0F -> portb_out = 0x33; ddrb_out is unchanged.
- Pin sync: pind_in 0x00 -> 0x81, read PIND on every cycle -> io_rdata = 0x81 first appears exactly SYNC_STAGES+1 cycles after the change edge.
- Simultaneous read/write of PORTD: old 0x11, write 0x22 with read -> io_rdata = 0x11; next read -> 0x22.
- Unmapped and mid-operation reset: write 0x55 to 0x09 -> no *_out changes, read 0x09 -> 0x00 with io_rvalid = 1. Then assert reset in the same cycle as a write of PORTB = 0xFF -> portb_out stays 0x00.
